pdp_exec_sequencer: RTL and testbench



---
 rtl/pdp_types_pkg.sv | 64 ++++++
 rtl/pdp_exec_sequencer_if.sv | 15 +
 rtl/pdp_ea_calc.sv | 16 +
 rtl/pdp_exec_sequencer.sv | 131 +++++++++++++
 tb/tb_pdp_exec_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdp_types_pkg.sv
// Shared PDP-8 decode types, sequencer state encoding and default timing.
package pdp_types_pkg;

  localparam int ADDR_WIDTH  = 12;
  localparam int PAGE_BITS   = 5;
  localparam int OFFSET_BITS = 7;

  localparam int DEF_LAT_OP7 = 1;
  localparam int DEF_LAT_MEM = 2;
  localparam int DEF_LAT_ISZ = 3;
  localparam int DEF_LAT_JMP = 1;

  // Decoded memory-reference instruction: one-hot opcode plus the 9-bit
  // address field (bit 8 indirect, bit 7 current page, bits 6:0 offset).
  typedef struct packed {
    logic AND;
    logic TAD;
    logic ISZ;
    logic DCA;
    logic JMS;
    logic JMP;
    logic [8:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  // Decoded operate (op7) instruction, one bit per micro-op group.
  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
    logic CLA2;
  } pdp_op7_opcode_s;

  typedef enum logic [1:0] {
    RESET_LOAD,
    WAIT,
    EXEC,
    HALT
  } seq_state_e;

  // An instruction word is well formed only when exactly one opcode bit is set.
  function automatic logic is_malformed(input logic [5:0] mem_bits,
                                        input logic [21:0] op7_bits);
    return ($countones({mem_bits, op7_bits}) > 1);
  endfunction

endpackage

// File: rtl/pdp_exec_sequencer_if.sv
// Decoder <-> exec sequencer handshake: decoded opcodes in, stall/PC back.
interface pdp_exec_sequencer_if;
  import pdp_types_pkg::*;

  pdp_mem_opcode_s       pdp_mem_opcode;
  pdp_op7_opcode_s       pdp_op7_opcode;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] PC_value;

  modport master (output pdp_mem_opcode, output pdp_op7_opcode,
                  input  stall, input PC_value);

  modport slave  (input  pdp_mem_opcode, input pdp_op7_opcode,
                  output stall, output PC_value);
endinterface

// File: rtl/pdp_ea_calc.sv
// Effective address for direct memory references: current page or page zero.
module pdp_ea_calc
  import pdp_types_pkg::*;
(
  input  logic [PAGE_BITS-1:0]   pc_page,
  input  logic [OFFSET_BITS:0]   addr,
  output logic [ADDR_WIDTH-1:0]  ea
);

  // Bit 7 of the address field selects the executing instruction's page.
  always_comb begin
    if (addr[OFFSET_BITS]) ea = {pc_page, addr[OFFSET_BITS-1:0]};
    else                   ea = {{PAGE_BITS{1'b0}}, addr[OFFSET_BITS-1:0]};
  end

endmodule

// File: rtl/pdp_exec_sequencer.sv
// Exec-side responder: accepts decoded instructions, stalls the decoder for
// each instruction's latency and owns the program counter.
module pdp_exec_sequencer
  import pdp_types_pkg::*;
#(
  parameter int LAT_OP7 = DEF_LAT_OP7,
  parameter int LAT_MEM = DEF_LAT_MEM,
  parameter int LAT_ISZ = DEF_LAT_ISZ,
  parameter int LAT_JMP = DEF_LAT_JMP
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  pdp_exec_sequencer_if.slave   exec,
  input  logic                  ac_is_zero,
  input  logic                  ac_is_neg,
  input  logic                  link,
  input  logic                  isz_zero,
  output logic                  halted,
  output logic                  illegal
);

  localparam int CNT_W = 8;

  seq_state_e            state, state_nxt;
  logic [5:0]            mem_bits;
  logic [21:0]           op7_bits;
  logic                  any_op, accept, malformed, indirect, done, skip;
  logic                  prev_any, rel_p0;
  logic [CNT_W-1:0]      cnt, lat_sel;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, ea;

  // Captured instruction, held for the whole execution.
  logic                  bad_p0, jmp_p0, jms_p0, isz_p0, hlt_p0;
  logic [6:0]            skip_p0;
  logic [OFFSET_BITS:0]  addr_p0;

  assign exec.PC_value = pc;

  pdp_ea_calc u_ea (
    .pc_page (pc[ADDR_WIDTH-1 -: PAGE_BITS]),
    .addr    (addr_p0),
    .ea      (ea)
  );

  // Decode the presented opcode: accept edge, class latency, error flags.
  always_comb begin
    mem_bits  = {exec.pdp_mem_opcode.AND, exec.pdp_mem_opcode.TAD,
                 exec.pdp_mem_opcode.ISZ, exec.pdp_mem_opcode.DCA,
                 exec.pdp_mem_opcode.JMS, exec.pdp_mem_opcode.JMP};
    op7_bits  = exec.pdp_op7_opcode;
    any_op    = (|mem_bits) | (|op7_bits);
    malformed = is_malformed(mem_bits, op7_bits);
    indirect  = (|mem_bits) & exec.pdp_mem_opcode.mem_inst_addr[8];
    accept    = (state == WAIT) & any_op & ~prev_any;
    if (malformed)                    lat_sel = CNT_W'(LAT_OP7);
    else if (exec.pdp_mem_opcode.JMP) lat_sel = CNT_W'(LAT_JMP);
    else if (exec.pdp_mem_opcode.ISZ) lat_sel = CNT_W'(LAT_ISZ);
    else if (|mem_bits)               lat_sel = CNT_W'(LAT_MEM);
    else                              lat_sel = CNT_W'(LAT_OP7);
  end

  // Next PC for the captured instruction; flags are live on the final edge.
  always_comb begin
    skip   = skip_p0[6]
           | (skip_p0[5] &  ac_is_zero) | (skip_p0[4] & ~ac_is_zero)
           | (skip_p0[3] &  ac_is_neg)  | (skip_p0[2] & ~ac_is_neg)
           | (skip_p0[1] & ~link)       | (skip_p0[0] &  link)
           | (isz_p0 & isz_zero);
    pc_nxt = pc + ADDR_WIDTH'(1);
    if (!bad_p0) begin
      if (jmp_p0)      pc_nxt = ea;
      else if (jms_p0) pc_nxt = ea + ADDR_WIDTH'(1);
      else if (skip)   pc_nxt = pc + ADDR_WIDTH'(2);
    end
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    done       = (state == EXEC) && (cnt == CNT_W'(1));
    exec.stall = (state != WAIT);
    halted     = (state == HALT);
    case (state)
      RESET_LOAD: if (rel_p0) state_nxt = WAIT;
      WAIT:       if (accept) state_nxt = EXEC;
      EXEC:       if (done)   state_nxt = (hlt_p0 && !bad_p0) ? HALT : WAIT;
      HALT:       state_nxt = HALT;
      default:    state_nxt = RESET_LOAD;
    endcase
  end

  // Control registers; rel_p0 re-times reset release and the RESET_LOAD
  // state flop forms the second synchronizer stage before the PC load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_LOAD;
      rel_p0   <= 1'b0;
      prev_any <= 1'b0;
      pc       <= '0;
      cnt      <= '0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rel_p0   <= 1'b1;
      prev_any <= any_op;
      illegal  <= accept & (malformed | indirect);
      if ((state == RESET_LOAD) && rel_p0) pc <= base_addr;
      else if (done)                       pc <= pc_nxt;
      if (accept)               cnt <= lat_sel;
      else if (state == EXEC)   cnt <= cnt - CNT_W'(1);
    end
  end

  // Instruction capture on accept; later opcode changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      bad_p0  <= malformed;
      jmp_p0  <= exec.pdp_mem_opcode.JMP;
      jms_p0  <= exec.pdp_mem_opcode.JMS;
      isz_p0  <= exec.pdp_mem_opcode.ISZ;
      hlt_p0  <= exec.pdp_op7_opcode.HLT;
      addr_p0 <= exec.pdp_mem_opcode.mem_inst_addr[OFFSET_BITS:0];
      skip_p0 <= {exec.pdp_op7_opcode.SKP, exec.pdp_op7_opcode.SZA,
                  exec.pdp_op7_opcode.SNA, exec.pdp_op7_opcode.SMA,
                  exec.pdp_op7_opcode.SPA, exec.pdp_op7_opcode.SZL,
                  exec.pdp_op7_opcode.SNL};
    end
  end

endmodule

// File: tb/tb_pdp_exec_sequencer.sv
// Bench for pdp_exec_sequencer: directed instruction stream, a behavioural
// model compared every cycle, and literal expectations per scenario.
module tb_pdp_exec_sequencer;
  import pdp_types_pkg::*;

  localparam logic [5:0] M_AND = 6'b100000;
  localparam logic [5:0] M_TAD = 6'b010000;
  localparam logic [5:0] M_ISZ = 6'b001000;
  localparam logic [5:0] M_DCA = 6'b000100;
  localparam logic [5:0] M_JMS = 6'b000010;
  localparam logic [5:0] M_JMP = 6'b000001;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [ADDR_WIDTH-1:0] base_addr = '0;
  logic                  ac_is_zero = 1'b0, ac_is_neg = 1'b0, link = 1'b0, isz_zero = 1'b0;
  logic                  halted, illegal;
  int                    n_checks = 0, n_fail = 0;
  bit                    check_en = 1'b0;

  pdp_exec_sequencer_if bus();

  pdp_exec_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .base_addr  (base_addr),
    .exec       (bus),
    .ac_is_zero (ac_is_zero),
    .ac_is_neg  (ac_is_neg),
    .link       (link),
    .isz_zero   (isz_zero),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'o%0o, expected 'o%0o at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int op_bits(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o);
    return $countones({m.AND, m.TAD, m.ISZ, m.DCA, m.JMS, m.JMP}) + $countones(o);
  endfunction

  function automatic bit is_mem(input pdp_mem_opcode_s m);
    return m.AND || m.TAD || m.ISZ || m.DCA || m.JMS || m.JMP;
  endfunction

  function automatic int op_latency(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o);
    if (op_bits(m, o) > 1) return 1;
    if (m.JMP) return 1;
    if (m.ISZ) return 3;
    if (is_mem(m)) return 2;
    return 1;
  endfunction

  function automatic int next_pc(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o,
                                 input bit bad, input int pc);
    int off, ea;
    bit sk;
    off = int'(m.mem_inst_addr) % 128;
    ea  = m.mem_inst_addr[7] ? (pc / 128) * 128 + off : off;
    if (bad)   return (pc + 1) % 4096;
    if (m.JMP) return ea;
    if (m.JMS) return (ea + 1) % 4096;
    sk = (m.ISZ && isz_zero) || o.SKP || (o.SZA && ac_is_zero) || (o.SNA && !ac_is_zero) ||
         (o.SMA && ac_is_neg) || (o.SPA && !ac_is_neg) || (o.SZL && !link) || (o.SNL && link);
    return (pc + (sk ? 2 : 1)) % 4096;
  endfunction

  bit              m_ready, m_halt, m_ill, m_prev, m_bad;
  int              m_rel, m_left, m_pc;
  pdp_mem_opcode_s m_mem;
  pdp_op7_opcode_s m_op7;

  initial begin : model
    bit any;
    m_ready = 0; m_halt = 0; m_ill = 0; m_prev = 0; m_bad = 0;
    m_rel = 0; m_left = 0; m_pc = 0; m_mem = '0; m_op7 = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_ready = 0; m_halt = 0; m_ill = 0; m_prev = 0;
        m_rel = 0; m_left = 0; m_pc = 0;
      end else begin
        m_ill = 0;
        any = op_bits(bus.pdp_mem_opcode, bus.pdp_op7_opcode) != 0;
        if (!m_ready) begin
          m_rel++;
          if (m_rel == 2) begin m_ready = 1; m_pc = int'(base_addr); end
        end else if (m_halt) begin
          m_halt = 1;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_pc = next_pc(m_mem, m_op7, m_bad, m_pc);
            if (m_op7.HLT && !m_bad) m_halt = 1;
          end
        end else if (any && !m_prev) begin
          m_mem  = bus.pdp_mem_opcode;
          m_op7  = bus.pdp_op7_opcode;
          m_bad  = op_bits(m_mem, m_op7) > 1;
          m_ill  = m_bad || (is_mem(m_mem) && m_mem.mem_inst_addr[8]);
          m_left = op_latency(m_mem, m_op7);
        end
        m_prev = any;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("model_stall",   32'(bus.stall), 32'(!m_ready || m_left > 0 || m_halt));
        check("model_pc",      32'(bus.PC_value), m_pc);
        check("model_halted",  32'(halted), 32'(m_halt));
        check("model_illegal", 32'(illegal), 32'(m_ill));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic pdp_mem_opcode_s mk_mem(input logic [5:0] flags, input logic [8:0] addr);
    pdp_mem_opcode_s m;
    m = '0;
    {m.AND, m.TAD, m.ISZ, m.DCA, m.JMS, m.JMP} = flags;
    m.mem_inst_addr = addr;
    return m;
  endfunction

  function automatic pdp_op7_opcode_s mk_op7(input string nm);
    pdp_op7_opcode_s o;
    o = '0;
    case (nm)
      "IAC":  o.IAC  = 1'b1;
      "HLT":  o.HLT  = 1'b1;
      "SKP":  o.SKP  = 1'b1;
      "SZA":  o.SZA  = 1'b1;
      "SNA":  o.SNA  = 1'b1;
      "SMA":  o.SMA  = 1'b1;
      "SPA":  o.SPA  = 1'b1;
      "SZL":  o.SZL  = 1'b1;
      "SNL":  o.SNL  = 1'b1;
      "CLA1": o.CLA1 = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o);
    bus.pdp_mem_opcode = m;
    bus.pdp_op7_opcode = o;
  endtask

  task automatic clr_op();
    bus.pdp_mem_opcode = '0;
    bus.pdp_op7_opcode = '0;
  endtask

  task automatic do_reset(input logic [ADDR_WIDTH-1:0] base);
    tick();
    reset = 1'b1;
    base_addr = base;
    check_en = 1'b1;
    #1;
    check("rst_stall",   32'(bus.stall), 1);
    check("rst_pc",      32'(bus.PC_value), 0);
    check("rst_halted",  32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);
    clr_op();
    repeat (3) tick();
    check("rst_hold_stall", 32'(bus.stall), 1);
    check("rst_hold_pc",    32'(bus.PC_value), 0);
    reset = 1'b0;
    tick();
    check("rel1_stall", 32'(bus.stall), 1);
    check("rel1_pc",    32'(bus.PC_value), 0);
    tick();
    check("rel2_stall", 32'(bus.stall), 0);
    check("rel2_pc",    32'(bus.PC_value), 32'(base));
  endtask

  task automatic run_instr(input string name, input pdp_mem_opcode_s m, input pdp_op7_opcode_s o,
                           input int exp_lat, input int exp_pc, input int exp_ill);
    int lat = 0;
    int ill = 0;
    set_op(m, o);
    tick();
    clr_op();
    while (bus.stall === 1'b1 && lat < 40) begin
      lat++;
      if (illegal === 1'b1) ill++;
      tick();
    end
    if (illegal === 1'b1) ill++;
    check({name, "_lat"},     lat, exp_lat);
    check({name, "_pc"},      32'(bus.PC_value), exp_pc);
    check({name, "_illegal"}, ill, exp_ill);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    pdp_mem_opcode_s nm;
    pdp_op7_opcode_s n7;
    nm = '0;
    n7 = '0;
    clr_op();

    do_reset(12'o0200);
    run_instr("iac", nm, mk_op7("IAC"), 1, 12'o0201, 0);

    // IAC held with no zero gap: one accept only
    set_op(nm, mk_op7("IAC"));
    repeat (6) tick();
    check("held_iac_stall", 32'(bus.stall), 0);
    clr_op();
    repeat (2) tick();
    check("held_iac_pc", 32'(bus.PC_value), 12'o0202);

    run_instr("and_iac", mk_mem(M_AND, 9'o000), mk_op7("IAC"), 1, 12'o0203, 1);
    run_instr("tad_ind", mk_mem(M_TAD, 9'o420), n7, 2, 12'o0204, 1);
    run_instr("dca",     mk_mem(M_DCA, 9'o050), n7, 2, 12'o0205, 0);
    isz_zero = 1'b1;
    run_instr("isz_z",   mk_mem(M_ISZ, 9'o060), n7, 3, 12'o0207, 0);
    isz_zero = 1'b0;
    run_instr("isz_nz",  mk_mem(M_ISZ, 9'o060), n7, 3, 12'o0210, 0);
    ac_is_neg = 1'b1;
    run_instr("sma", nm, mk_op7("SMA"), 1, 12'o0212, 0);
    run_instr("spa", nm, mk_op7("SPA"), 1, 12'o0213, 0);
    link = 1'b1;
    run_instr("snl", nm, mk_op7("SNL"), 1, 12'o0215, 0);
    run_instr("szl", nm, mk_op7("SZL"), 1, 12'o0216, 0);
    ac_is_zero = 1'b0;
    run_instr("sna", nm, mk_op7("SNA"), 1, 12'o0220, 0);
    run_instr("skp", nm, mk_op7("SKP"), 1, 12'o0222, 0);
    run_instr("cla", nm, mk_op7("CLA1"), 1, 12'o0223, 0);

    // isz_zero only valid at the final execution edge
    set_op(mk_mem(M_ISZ, 9'o070), n7);
    tick();
    clr_op();
    tick();
    isz_zero = 1'b1;
    repeat (3) tick();
    check("isz_late_flag_pc", 32'(bus.PC_value), 12'o0225);
    isz_zero = 1'b0;

    do_reset(12'o1234);
    run_instr("jmp_cur", mk_mem(M_JMP, 9'o245), n7, 1, 12'o1245, 0);
    run_instr("jms_pz",  mk_mem(M_JMS, 9'o045), n7, 2, 12'o0046, 0);

    // opcode swapped to JMP mid-execution of JMS: captured JMS wins
    set_op(mk_mem(M_JMS, 9'o010), n7);
    tick();
    set_op(mk_mem(M_JMP, 9'o300), n7);
    repeat (3) tick();
    check("exec_change_pc", 32'(bus.PC_value), 12'o0011);
    clr_op();
    tick();
    check("exec_change_stall", 32'(bus.stall), 0);
    check("exec_change_pc2",   32'(bus.PC_value), 12'o0011);

    ac_is_zero = 1'b0;
    do_reset(12'o7776);
    run_instr("sza_nz", nm, mk_op7("SZA"), 1, 12'o7777, 0);
    ac_is_zero = 1'b1;
    run_instr("sza_wrap1", nm, mk_op7("SZA"), 1, 12'o0001, 0);
    do_reset(12'o7776);
    run_instr("sza_wrap0", nm, mk_op7("SZA"), 1, 12'o0000, 0);

    // HLT: stuck stalled and halted regardless of later opcodes
    set_op(nm, mk_op7("HLT"));
    tick();
    clr_op();
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) set_op(nm, mk_op7("IAC"));
      else clr_op();
      tick();
      check("hlt_stall",  32'(bus.stall), 1);
      check("hlt_halted", 32'(halted), 1);
      check("hlt_pc",     32'(bus.PC_value), 12'o0001);
    end
    clr_op();

    do_reset(12'o0500);
    run_instr("post_halt_iac", nm, mk_op7("IAC"), 1, 12'o0501, 0);

    // reset lands in the middle of an ISZ
    set_op(mk_mem(M_ISZ, 9'o010), n7);
    tick();
    clr_op();
    tick();
    check("isz_mid_stall", 32'(bus.stall), 1);
    do_reset(12'o0300);
    run_instr("restart_iac", nm, mk_op7("IAC"), 1, 12'o0301, 0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
